// File: rtl/mod_dp.sv
// mod_dp: datapath of the repeated-subtraction modulo unit.
//
// Holds the dividend (remainder register) and divisor, subtracts the divisor
// once per cycle while the control unit requests it, and reports completion.
//
// Ports:
//   clk             in   system clock, rising edge
//   reset           in   synchronous, active-high reset
//   load            in   one-cycle pulse: capture a_in/b_in, start new operation
//   a_in            in   dividend, sampled on load
//   b_in            in   divisor, sampled on load
//   subtract_enable in   control unit requests one subtraction this cycle
//   lt              out  remainder < divisor, or divisor zero (combinational)
//   remainder       out  current remainder; final result when done=1
//   quotient        out  subtractions performed since load
//   done            out  result valid, held until next load or reset
//   div_zero        out  divisor captured on last load was zero
module mod_dp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             subtract_enable,
    output logic             lt,
    output logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] quotient,
    output logic             done,
    output logic             div_zero
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    // A zero divisor forces lt so the subtract guard below can never loop
    // forever and the control unit sees completion immediately.
    assign lt = (div_q == '0) || (rem_q < div_q);

    always_comb begin
        rem_d      = rem_q;
        div_d      = div_q;
        quotient_d = quotient_q;
        done_d     = done_q;
        div_zero_d = div_zero_q;

        if (load) begin
            rem_d      = a_in;
            div_d      = b_in;
            quotient_d = '0;
            done_d     = 1'b0;
            div_zero_d = (b_in == '0);
        end else begin
            // Subtraction is gated by lt locally, so a late or early request
            // from the control unit cannot underflow the remainder.
            if (subtract_enable && !lt) begin
                rem_d      = rem_q - div_q;
                quotient_d = quotient_q + 1'b1;
            end
            // Sticky: once set, only load or reset clears it.
            if (lt) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q      <= '0;
            div_q      <= '0;
            quotient_q <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            rem_q      <= rem_d;
            div_q      <= div_d;
            quotient_q <= quotient_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign remainder = rem_q;
    assign quotient  = quotient_q;
    assign done      = done_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_mod_dp.sv
// tb_mod_dp: directed-vector bench for mod_dp with hand-computed expectations.
module tb_mod_dp;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             subtract_enable;
    logic             lt;
    logic [WIDTH-1:0] remainder;
    logic [WIDTH-1:0] quotient;
    logic             done;
    logic             div_zero;

    int n_vec;
    int n_miscompare;

    mod_dp #(.WIDTH(WIDTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .load            (load),
        .a_in            (a_in),
        .b_in            (b_in),
        .subtract_enable (subtract_enable),
        .lt              (lt),
        .remainder       (remainder),
        .quotient        (quotient),
        .done            (done),
        .div_zero        (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance one rising edge and settle; inputs are then changed and outputs
    // sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        load = 1'b1;
        a_in = a;
        b_in = b;
        step();
        load = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] rem, input logic [31:0] quo,
                             input logic l, input logic d, input logic dz);
        chk({tag, ".rem"}, remainder, rem);
        chk({tag, ".quo"}, quotient, quo);
        chk({tag, ".lt"},  {31'd0, lt}, {31'd0, l});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
        chk({tag, ".dz"},  {31'd0, div_zero}, {31'd0, dz});
    endtask

    initial begin
        n_vec = 0;
        n_miscompare = 0;
        reset = 1'b1;
        load = 1'b0;
        a_in = '0;
        b_in = '0;
        subtract_enable = 1'b0;

        // Reset state
        step();
        step();
        chk_state("reset", 0, 0, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;

        // 17 mod 5
        subtract_enable = 1'b1;
        do_load(17, 5);
        chk_state("n17.load", 17, 0, 1'b0, 1'b0, 1'b0);
        step();
        chk_state("n17.s1", 12, 1, 1'b0, 1'b0, 1'b0);
        step();
        chk_state("n17.s2", 7, 2, 1'b0, 1'b0, 1'b0);
        step();
        chk_state("n17.s3", 2, 3, 1'b1, 1'b0, 1'b0);
        step();
        chk_state("n17.done", 2, 3, 1'b1, 1'b1, 1'b0);
        step();
        chk_state("n17.hold", 2, 3, 1'b1, 1'b1, 1'b0);

        // 9 mod 9
        do_load(9, 9);
        chk_state("eq.load", 9, 0, 1'b0, 1'b0, 1'b0);
        step();
        chk_state("eq.s1", 0, 1, 1'b1, 1'b0, 1'b0);
        step();
        chk_state("eq.done", 0, 1, 1'b1, 1'b1, 1'b0);

        // 3 mod 7: subtract requests ignored
        do_load(3, 7);
        chk_state("lt.load", 3, 0, 1'b1, 1'b0, 1'b0);
        step();
        chk_state("lt.done", 3, 0, 1'b1, 1'b1, 1'b0);
        subtract_enable = 1'b0;
        step();
        subtract_enable = 1'b1;
        step();
        chk_state("lt.hold", 3, 0, 1'b1, 1'b1, 1'b0);

        // 42 mod 0
        do_load(42, 0);
        chk_state("dz.load", 42, 0, 1'b1, 1'b0, 1'b1);
        step();
        chk_state("dz.done", 42, 0, 1'b1, 1'b1, 1'b1);
        step();
        chk_state("dz.hold", 42, 0, 1'b1, 1'b1, 1'b1);

        // 100 mod 7 interrupted by load 10 mod 4 with subtract_enable high
        do_load(100, 7);
        chk_state("pri.load", 100, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step();
        chk_state("pri.q5", 65, 5, 1'b0, 1'b0, 1'b0);
        do_load(10, 4);
        chk_state("pri.reload", 10, 0, 1'b0, 1'b0, 1'b0);
        step();
        chk_state("pri.s1", 6, 1, 1'b0, 1'b0, 1'b0);
        step();
        chk_state("pri.s2", 2, 2, 1'b1, 1'b0, 1'b0);
        step();
        chk_state("pri.done", 2, 2, 1'b1, 1'b1, 1'b0);

        // 50 mod 3 interrupted by reset
        do_load(50, 3);
        for (int i = 0; i < 4; i++) step();
        chk_state("rst.q4", 38, 4, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        chk_state("rst.clear", 0, 0, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        do_load(50, 3);
        chk_state("rst.load", 50, 0, 1'b0, 1'b0, 1'b0);
        begin
            int cyc;
            cyc = 0;
            while (!done && cyc < 40) begin
                step();
                cyc++;
            end
            chk("rst.cycles_to_done", cyc, 17);
        end
        chk_state("rst.final", 2, 16, 1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule

// File: doc/mod_dp.md
Name: mod_dp

Overview:
- Datapath for the repeated-subtraction modulo unit, paired with the modulo control unit.
- Holds the dividend and divisor, performs one subtraction per cycle while `subtract_enable` is high, and drives `lt` back to the control unit.
- Exposes the remainder, the quotient (subtraction count), a done flag and a divide-by-zero flag to the surrounding system.

Parameters:
- WIDTH, 32, operand, remainder and quotient width in bits (unsigned).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  one-cycle pulse; captures a_in/b_in and starts a new operation.
- a_in  input  WIDTH  dividend, sampled on load.
- b_in  input  WIDTH  divisor, sampled on load.
- subtract_enable  input  1  from control unit; request one subtraction this cycle.
- lt  output  1  remainder < divisor (or divisor zero); combinational from registers, to control unit.
- remainder  output  WIDTH  current remainder register; final result when done=1.
- quotient  output  WIDTH  number of subtractions performed since load.
- done  output  1  result valid; held until next load or reset.
- div_zero  output  1  divisor captured on last load was zero; held until next load or reset.

Behaviour:
- Clock/reset: reset is synchronous, active-high; clock is clk.
- On reset (highest priority):
  - rem_q, div_q and quotient go to 0.
  - done and div_zero go to 0.
  - lt therefore reads 1, because divisor==0 forces it.
- Comparator: lt = (div_q == 0) | (rem_q < div_q), unsigned, combinational from registers.
  - Valid in the same cycle a register updates; no extra pipeline stage.
- Load (reset low, load high):
  - rem_q <= a_in, div_q <= b_in, quotient <= 0, done <= 0.
  - div_zero <= (b_in == 0).
  - Load wins over subtract_enable in the same cycle.
- Subtract (reset low, load low, subtract_enable high, lt low):
  - rem_q <= rem_q - div_q; quotient <= quotient + 1.
  - No underflow is possible because lt is low.
- Guard: subtract_enable high while lt high leaves rem_q and quotient unchanged.
  - The datapath never underflows regardless of control-unit timing.
- Done:
  - done <= 1 at any edge with reset low, load low and lt high.
  - Once set, done stays 1 until the next load or reset.
  - done is never set on the load edge itself: first possible assertion is one cycle after load.
- Latency:
  - For a >= b > 0: remainder is final after floor(a/b) subtract cycles.
  - done rises on the first edge after that at which lt is sampled high.
- Divide by zero:
  - lt=1 immediately; remainder=a, quotient=0, div_zero=1.
  - done asserts on the next edge.
- a < b: lt=1 right after load; zero subtractions; remainder=a, quotient=0.
- Quotient wrap: not reachable for b >= 1, since quotient <= a < 2^WIDTH. No saturation logic is required.
- Reset mid-operation: all state clears on that edge and any in-progress result is discarded.
- Load mid-operation: restarts cleanly with the new operands; the previous result is discarded.

Test Plan:
- Normal case: reset, load a=17 b=5, then hold subtract_enable=1.
  - Exactly 3 subtracting cycles (rem 17→12→7→2); lt=1 after the third.
  - Final: remainder=2, quotient=3, done=1, div_zero=0.
- Equal operands: load a=9 b=9, subtract_enable=1 → one subtraction; remainder=0, quotient=1, lt=1, done=1.
- a < b: load a=3 b=7 → lt=1 the cycle after load; subtract_enable pulses ignored; remainder=3, quotient=0, done=1 next edge.
- Divide by zero: load a=42 b=0 → div_zero=1 and lt=1 the cycle after load; remainder=42, quotient=0, done=1; subtract_enable=1 causes no change.
- Load priority and restart: during 100 mod 7 (quotient at 5), assert load a=10 b=4 together with subtract_enable=1.
  - Next cycle: rem=10, quotient=0, done=0.
  - Completion: remainder=2, quotient=2.
- Reset mid-op: assert reset during 50 mod 3 → next cycle remainder=0, quotient=0, done=0, div_zero=0, lt=1.
  - A subsequent load a=50 b=3 completes with remainder=2, quotient=16.
